// File: rtl/scoring_pkg.sv
// Shared types and helpers for the per-player high-score tracker.
// State encoding plus BCD range helpers used by the converter.
package scoring_pkg;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_RD   = 3'd2,
    S_WT   = 3'd3,
    S_CMP  = 3'd4,
    S_WR   = 3'd5,
    S_DONE = 3'd6
  } state_e;

  function automatic int bcd_max(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

  // True when every w-bit value fits in the digit count.
  function automatic bit bcd_fits(input int w, input int digits);
    return ((1 << w) - 1) <= bcd_max(digits);
  endfunction

endpackage

// File: rtl/scoring_table_bin2bcd.sv
// Combinational double-dabble binary to packed BCD.
// Values above the displayable range show all nines.
module bin2bcd
  import scoring_pkg::*;
#(
  parameter int SCORE_W = 7,
  parameter int DIGITS  = 3
) (
  input  logic [SCORE_W-1:0]  bin,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int MAX = bcd_max(DIGITS);
  localparam bit SAT = !bcd_fits(SCORE_W, DIGITS);

  logic [4*DIGITS-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = SCORE_W - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (acc[4*d +: 4] >= 4'd5)
          acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
      acc = {acc[4*DIGITS-2:0], bin[i]};
    end
    bcd = acc;
    if (SAT && (int'(bin) > MAX))
      bcd = {DIGITS{4'h9}};
  end

endmodule

// File: rtl/scoring_table.sv
// Per-player high-score tracker with external synchronous RAM,
// global best tracking and registered BCD display output.
module scoring_table
  import scoring_pkg::*;
#(
  parameter int ID_W    = 5,
  parameter int SCORE_W = 7,
  parameter int NUM_REG = 16,
  parameter int DIGITS  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                score_request,
  input  logic                clear_request,
  input  logic [ID_W-1:0]     playerID,
  input  logic [SCORE_W-1:0]  score,
  output logic                ready,
  output logic                valid,
  output logic                pwinner,
  output logic                gwinner,
  output logic [ID_W-1:0]     gwin_id,
  output logic [ID_W-1:0]     RAMaddr,
  output logic [SCORE_W-1:0]  toRAM,
  output logic                WRen,
  input  logic [SCORE_W-1:0]  fromRAM,
  output logic [4*DIGITS-1:0] bcd_out
);

  state_e state_q, state_d;

  logic [ID_W-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                p_q, p_d;
  logic                g_q, g_d;
  logic [SCORE_W-1:0]  gbest_q, gbest_d;
  logic [ID_W-1:0]     gwin_id_q, gwin_id_d;
  logic                pwin_q, pwin_d;
  logic                gwin_q, gwin_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;
  logic [ID_W-1:0]     addr_q, addr_d;
  logic [SCORE_W-1:0]  toram_q, toram_d;
  logic                wren_q, wren_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [4*DIGITS-1:0] bcd_w;

  bin2bcd #(
    .SCORE_W (SCORE_W),
    .DIGITS  (DIGITS)
  ) u_bin2bcd (
    .bin (gbest_q),
    .bcd (bcd_w)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    score_d   = score_q;
    p_d       = p_q;
    g_d       = g_q;
    gbest_d   = gbest_q;
    gwin_id_d = gwin_id_q;
    pwin_d    = pwin_q;
    gwin_d    = gwin_q;
    valid_d   = 1'b0;
    addr_d    = addr_q;
    toram_d   = toram_q;
    wren_d    = 1'b0;
    bcd_d     = bcd_w;
    unique case (state_q)
      S_INIT: begin
        wren_d  = 1'b1;
        toram_d = '0;
        addr_d  = cnt_q;
        cnt_d   = cnt_q + ID_W'(1);
        if (cnt_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        // Clear outranks a simultaneous score request.
        if (clear_request) begin
          gbest_d   = '0;
          gwin_id_d = '0;
          pwin_d    = 1'b0;
          gwin_d    = 1'b0;
          cnt_d     = '0;
          state_d   = S_INIT;
        end else if (score_request) begin
          id_d    = playerID;
          score_d = score;
          addr_d  = playerID;
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_WT;
      S_WT: state_d = S_CMP;
      S_CMP: begin
        p_d = (int'(id_q) < NUM_REG) && (score_q > fromRAM);
        g_d = score_q > gbest_q;
        if (p_d) begin
          wren_d  = 1'b1;
          toram_d = score_q;
          addr_d  = id_q;
          state_d = S_WR;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WR: state_d = S_DONE;
      S_DONE: begin
        valid_d = 1'b1;
        pwin_d  = p_q;
        gwin_d  = g_q;
        if (g_q) begin
          gbest_d   = score_q;
          gwin_id_d = id_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      id_q      <= '0;
      score_q   <= '0;
      p_q       <= 1'b0;
      g_q       <= 1'b0;
      gbest_q   <= '0;
      gwin_id_q <= '0;
      pwin_q    <= 1'b0;
      gwin_q    <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      addr_q    <= '0;
      toram_q   <= '0;
      wren_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      score_q   <= score_d;
      p_q       <= p_d;
      g_q       <= g_d;
      gbest_q   <= gbest_d;
      gwin_id_q <= gwin_id_d;
      pwin_q    <= pwin_d;
      gwin_q    <= gwin_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      addr_q    <= addr_d;
      toram_q   <= toram_d;
      wren_q    <= wren_d;
      bcd_q     <= bcd_d;
    end
  end

  assign ready   = ready_q;
  assign valid   = valid_q;
  assign pwinner = pwin_q;
  assign gwinner = gwin_q;
  assign gwin_id = gwin_id_q;
  assign RAMaddr = addr_q;
  assign toRAM   = toram_q;
  assign WRen    = wren_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_scoring_table.sv
// Scoreboard bench for scoring_table: directed requests, monitor
// checks results, latency and RAM writes on each valid pulse.
module tb_scoring_table;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       score_request = 1'b0;
  logic       clear_request = 1'b0;
  logic [4:0] playerID = '0;
  logic [6:0] score = '0;

  logic       ready, valid, pwinner, gwinner, WRen;
  logic [4:0] gwin_id, RAMaddr;
  logic [6:0] toRAM, fromRAM;
  logic [11:0] bcd_out;

  logic       ready2, valid2, pwinner2, gwinner2, WRen2;
  logic [4:0] gwin_id2, RAMaddr2;
  logic [6:0] toRAM2, fromRAM2;
  logic [7:0] bcd_out2;

  logic [6:0] mem1 [32];
  logic [6:0] mem2 [32];

  always #5 clk = ~clk;

  scoring_table #(
    .ID_W(5), .SCORE_W(7), .NUM_REG(16), .DIGITS(3)
  ) u_dut (
    .clk(clk), .rst(rst),
    .score_request(score_request),
    .clear_request(clear_request),
    .playerID(playerID), .score(score),
    .ready(ready), .valid(valid),
    .pwinner(pwinner), .gwinner(gwinner),
    .gwin_id(gwin_id), .RAMaddr(RAMaddr),
    .toRAM(toRAM), .WRen(WRen),
    .fromRAM(fromRAM), .bcd_out(bcd_out)
  );

  scoring_table #(
    .ID_W(5), .SCORE_W(7), .NUM_REG(16), .DIGITS(2)
  ) u_dut2 (
    .clk(clk), .rst(rst),
    .score_request(score_request),
    .clear_request(clear_request),
    .playerID(playerID), .score(score),
    .ready(ready2), .valid(valid2),
    .pwinner(pwinner2), .gwinner(gwinner2),
    .gwin_id(gwin_id2), .RAMaddr(RAMaddr2),
    .toRAM(toRAM2), .WRen(WRen2),
    .fromRAM(fromRAM2), .bcd_out(bcd_out2)
  );

  always @(posedge clk) begin
    if (WRen) mem1[RAMaddr] <= toRAM;
    fromRAM <= mem1[RAMaddr];
    if (WRen2) mem2[RAMaddr2] <= toRAM2;
    fromRAM2 <= mem2[RAMaddr2];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       p;
    logic       g;
    logic [4:0] id;
    int         lat;
    int         acc;
    logic       wr;
    logic [6:0] sc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [4:0] wr_addr = '0;
  logic [6:0] wr_data = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every valid pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        wr_cnt = 0;
      end else begin
        if (WRen && toRAM != '0) begin
          wr_cnt++;
          wr_addr = RAMaddr;
          wr_data = toRAM;
        end
        if (valid) begin
          if (sbq.size() == 0) begin
            chk("valid_unexpected", valid, 0);
          end else begin
            e = sbq.pop_front();
            chk("pwinner", pwinner, e.p);
            chk("gwinner", gwinner, e.g);
            chk("gwin_id", gwin_id, e.id);
            chk("latency", cyc - e.acc, e.lat);
            chk("wr_count", wr_cnt, e.wr);
            if (e.wr) begin
              chk("wr_data", wr_data, e.sc);
            end
            wr_cnt = 0;
          end
        end
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) return;
    end
    chk("ready_timeout", ready, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sbq.size() == 0) break;
    end
    chk("sb_drain", sbq.size(), 0);
  endtask

  task automatic send(input logic [4:0] id, input logic [6:0] sc,
                      input logic p, input logic g,
                      input logic [4:0] gid, input int lat);
    exp_t e;
    wait_ready();
    playerID = id;
    score = sc;
    score_request = 1'b1;
    @(posedge clk);
    #1;
    e = '{p, g, gid, lat, cyc, p, sc};
    sbq.push_back(e);
    score_request = 1'b0;
  endtask

  // Call just after the edge that enters INIT (or reset release).
  task automatic check_sweep(input string tag);
    logic ok;
    int seen;
    ok = 1'b1;
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k <= 32 && !(WRen && RAMaddr == 5'(k - 1) && toRAM == '0))
        ok = 1'b0;
      if (ready) begin
        seen = k;
        break;
      end
    end
    chk({tag, "_ready_low_cycles"}, seen, 32);
    chk({tag, "_sweep_writes"}, ok, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // T1: reset state and initial sweep
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {ready, valid, pwinner, gwinner, WRen}, 0);
    chk("rst_bus", {gwin_id, RAMaddr, toRAM}, 0);
    chk("rst_bcd", bcd_out, 0);
    rst = 1'b1;
    check_sweep("init");
    chk("post_init_outs", {valid, pwinner, gwinner, gwin_id}, 0);
    chk("post_init_bcd", bcd_out, 0);

    // T2: first score for player 1
    send(5'd1, 7'd15, 1, 1, 5'd1, 5);
    drain();
    repeat (2) @(negedge clk);
    chk("bcd_15", bcd_out, 12'h015);
    chk("bcd2_15", bcd_out2, 8'h15);

    // T3: tie does not win
    send(5'd1, 7'd15, 0, 0, 5'd1, 4);
    drain();

    // T4: registered then guest
    send(5'd2, 7'd70, 1, 1, 5'd2, 5);
    send(5'd20, 7'd80, 0, 1, 5'd20, 4);
    drain();
    repeat (2) @(negedge clk);
    chk("bcd_80", bcd_out, 12'h080);
    chk("bcd2_80", bcd_out2, 8'h80);

    // T5: requests while busy are ignored
    send(5'd3, 7'd127, 1, 1, 5'd3, 5);
    playerID = 5'd4;
    score = 7'd100;
    score_request = 1'b1;
    repeat (3) @(negedge clk);
    score_request = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    chk("busy_no_extra", sbq.size(), 0);
    chk("bcd_127", bcd_out, 12'h127);
    chk("bcd2_sat", bcd_out2, 8'h99);

    // T6: clear beats simultaneous score request
    wait_ready();
    clear_request = 1'b1;
    score_request = 1'b1;
    playerID = 5'd5;
    score = 7'd50;
    @(posedge clk);
    #1;
    clear_request = 1'b0;
    score_request = 1'b0;
    check_sweep("clear");
    chk("clear_outs", {pwinner, gwinner, gwin_id}, 0);
    repeat (2) @(negedge clk);
    chk("clear_bcd", bcd_out, 0);
    chk("clear_bcd2", bcd_out2, 0);
    send(5'd1, 7'd5, 1, 1, 5'd1, 5);
    drain();

    // T7: reset while in WT drops the request
    wait_ready();
    playerID = 5'd6;
    score = 7'd9;
    score_request = 1'b1;
    @(posedge clk);
    #1;
    score_request = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_flags", {ready, valid, pwinner, gwinner, WRen}, 0);
    chk("midrst_gwin", gwin_id, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reinit_addr0", {WRen, RAMaddr}, {1'b1, 5'd0});
    wait_ready();
    chk("midrst_no_pending", sbq.size(), 0);
    send(5'd6, 7'd9, 1, 1, 5'd6, 5);
    send(5'd1, 7'd3, 1, 0, 5'd6, 5);
    drain();
    repeat (3) @(negedge clk);
    chk("bcd_9", bcd_out, 12'h009);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
